// File: rtl/micro_dispatch_seq.sv
// micro_dispatch_seq: microprogram sequencer holding the micro-PC.
// Each cycle the next uPC is a fetch, a sequential increment, or a
// dispatch through one of two run-time-programmable masked tables keyed
// on {opcode, funct}. Unmatched keys go to a trap state and raise a
// sticky illegal flag. All outputs are registered.
module micro_dispatch_seq #(
    parameter int STATE_W     = 5,
    parameter int OPC_W       = 6,
    parameter int FN_W        = 6,
    parameter int DT_DEPTH    = 8,
    parameter int FETCH_STATE = 0,
    parameter int TRAP_STATE  = 31,
    parameter int KEY_W       = OPC_W + FN_W,
    parameter int IDX_W       = $clog2(DT_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic [1:0]         addr_ctl,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [FN_W-1:0]    funct,
    input  logic               cfg_we,
    input  logic               cfg_table,
    input  logic [IDX_W-1:0]   cfg_index,
    input  logic               cfg_valid,
    input  logic [KEY_W-1:0]   cfg_key,
    input  logic [KEY_W-1:0]   cfg_mask,
    input  logic [STATE_W-1:0] cfg_target,
    input  logic               illegal_clr,
    output logic [STATE_W-1:0] upc,
    output logic               miss,
    output logic               illegal
);

    localparam logic [STATE_W-1:0] FETCH_UPC = STATE_W'(FETCH_STATE);
    localparam logic [STATE_W-1:0] TRAP_UPC  = STATE_W'(TRAP_STATE);
    localparam logic [STATE_W-1:0] ONE_UPC   = STATE_W'(1);

    // Dispatch tables, index [table][entry]. Only valid bits are reset.
    logic [DT_DEPTH-1:0] valid_r  [0:1];
    logic [KEY_W-1:0]    key_r    [0:1][0:DT_DEPTH-1];
    logic [KEY_W-1:0]    mask_r   [0:1][0:DT_DEPTH-1];
    logic [STATE_W-1:0]  target_r [0:1][0:DT_DEPTH-1];

    // Sequencer state
    logic [STATE_W-1:0] upc_r;
    logic               miss_r;
    logic               illegal_r;

    // Combinational lookup and next-state values
    logic               tbl_s;
    logic [KEY_W-1:0]   lookup_key_s;
    logic               hit_s;
    logic [STATE_W-1:0] hit_tgt_s;
    logic [STATE_W-1:0] upc_nxt_s;
    logic               miss_nxt_s;
    logic               illegal_nxt_s;

    assign tbl_s        = (addr_ctl == 2'b10) ? 1'b1 : 1'b0;
    assign lookup_key_s = {opcode, funct};

    // Table write port: clears valid bits on reset, otherwise writes one full entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r[0] <= {DT_DEPTH{1'b0}};
            valid_r[1] <= {DT_DEPTH{1'b0}};
        end else if (cfg_we) begin
            valid_r[cfg_table][cfg_index]  <= cfg_valid;
            key_r[cfg_table][cfg_index]    <= cfg_key;
            mask_r[cfg_table][cfg_index]   <= cfg_mask;
            target_r[cfg_table][cfg_index] <= cfg_target;
        end
    end

    // Masked priority lookup; scanning downward lets the lowest matching index win.
    always_comb begin
        hit_s     = 1'b0;
        hit_tgt_s = {STATE_W{1'b0}};
        for (int i = DT_DEPTH - 1; i >= 0; i--) begin
            if (valid_r[tbl_s][i] &&
                (((lookup_key_s ^ key_r[tbl_s][i]) & mask_r[tbl_s][i]) == {KEY_W{1'b0}})) begin
                hit_s     = 1'b1;
                hit_tgt_s = target_r[tbl_s][i];
            end else begin
                hit_s     = hit_s;
                hit_tgt_s = hit_tgt_s;
            end
        end
    end

    // Next uPC / miss / illegal selection; a stall freezes the uPC and suppresses misses.
    always_comb begin
        upc_nxt_s  = upc_r;
        miss_nxt_s = 1'b0;
        if (stall) begin
            upc_nxt_s  = upc_r;
            miss_nxt_s = 1'b0;
        end else begin
            case (addr_ctl)
                2'b00: upc_nxt_s = FETCH_UPC;
                2'b01,
                2'b10: begin
                    if (hit_s) begin
                        upc_nxt_s  = hit_tgt_s;
                        miss_nxt_s = 1'b0;
                    end else begin
                        upc_nxt_s  = TRAP_UPC;
                        miss_nxt_s = 1'b1;
                    end
                end
                2'b11:   upc_nxt_s = upc_r + ONE_UPC;
                default: upc_nxt_s = FETCH_UPC;
            endcase
        end
        // A miss in the same cycle as a clear keeps the flag set.
        if (miss_nxt_s) begin
            illegal_nxt_s = 1'b1;
        end else if (illegal_clr) begin
            illegal_nxt_s = 1'b0;
        end else begin
            illegal_nxt_s = illegal_r;
        end
    end

    // Sequencer state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            upc_r     <= FETCH_UPC;
            miss_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            upc_r     <= upc_nxt_s;
            miss_r    <= miss_nxt_s;
            illegal_r <= illegal_nxt_s;
        end
    end

    assign upc     = upc_r;
    assign miss    = miss_r;
    assign illegal = illegal_r;

endmodule

// File: tb/tb_micro_dispatch_seq.sv
// Self-checking bench for micro_dispatch_seq: each stimulus cycle pushes
// its expected {upc, miss, illegal} to a scoreboard, which is popped and
// compared once the DUT has clocked that cycle.
module tb_micro_dispatch_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  addr_ctl;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        cfg_we;
    logic        cfg_table;
    logic [2:0]  cfg_index;
    logic        cfg_valid;
    logic [11:0] cfg_key;
    logic [11:0] cfg_mask;
    logic [4:0]  cfg_target;
    logic        illegal_clr;
    logic [4:0]  upc;
    logic        miss;
    logic        illegal;

    typedef struct packed {
        logic [4:0] upc;
        logic       miss;
        logic       ill;
    } exp_t;

    exp_t sb_q[$];
    int   checks_cnt = 0;
    int   fail_cnt   = 0;

    micro_dispatch_seq dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .addr_ctl    (addr_ctl),
        .opcode      (opcode),
        .funct       (funct),
        .cfg_we      (cfg_we),
        .cfg_table   (cfg_table),
        .cfg_index   (cfg_index),
        .cfg_valid   (cfg_valid),
        .cfg_key     (cfg_key),
        .cfg_mask    (cfg_mask),
        .cfg_target  (cfg_target),
        .illegal_clr (illegal_clr),
        .upc         (upc),
        .miss        (miss),
        .illegal     (illegal)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks_cnt++;
        if (obs !== exp_v) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One cycle: drive inputs, push expectation, clock, pop and compare.
    task automatic step(input string tag, input logic st, input logic [1:0] ac,
                        input logic [5:0] opc, input logic [5:0] fn, input logic clr,
                        input logic [4:0] e_upc, input logic e_miss, input logic e_ill);
        exp_t e;
        stall       = st;
        addr_ctl    = ac;
        opcode      = opc;
        funct       = fn;
        illegal_clr = clr;
        sb_q.push_back('{upc: e_upc, miss: e_miss, ill: e_ill});
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        check_eq({tag, ".upc"},     {27'd0, upc},     {27'd0, e.upc});
        check_eq({tag, ".miss"},    {31'd0, miss},    {31'd0, e.miss});
        check_eq({tag, ".illegal"}, {31'd0, illegal}, {31'd0, e.ill});
        cfg_we = 1'b0;
    endtask

    // Config write performed while stalled so the uPC holds.
    task automatic cfg_write(input logic tbl, input logic [2:0] idx, input logic v,
                             input logic [11:0] k, input logic [11:0] m, input logic [4:0] t,
                             input logic [4:0] hold_upc, input logic hold_ill);
        cfg_we     = 1'b1;
        cfg_table  = tbl;
        cfg_index  = idx;
        cfg_valid  = v;
        cfg_key    = k;
        cfg_mask   = m;
        cfg_target = t;
        step("cfg", 1'b1, 2'b01, 6'd0, 6'd0, 1'b0, hold_upc, 1'b0, hold_ill);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; addr_ctl = 2'b11; opcode = 6'd0; funct = 6'd0;
        cfg_we = 1'b0; cfg_table = 1'b0; cfg_index = 3'd0; cfg_valid = 1'b0;
        cfg_key = 12'd0; cfg_mask = 12'd0; cfg_target = 5'd0; illegal_clr = 1'b0;

        // Reset for two cycles
        step("rst0", 1'b0, 2'b11, 6'd0, 6'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        step("rst1", 1'b0, 2'b11, 6'd0, 6'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Sequential count 1..31, wrap to 0, then 1
        for (int i = 1; i <= 33; i++) begin
            step($sformatf("seq%0d", i), 1'b0, 2'b11, 6'd0, 6'd0, 1'b0,
                 5'(i % 32), 1'b0, 1'b0);
        end

        // Table programming (uPC holds at 1)
        cfg_write(1'b1, 3'd0, 1'b1, {6'b100011, 6'b000000}, {6'b111111, 6'b000000}, 5'd23, 5'd1, 1'b0);
        cfg_write(1'b1, 3'd1, 1'b1, 12'd0, 12'd0, 5'd25, 5'd1, 1'b0);
        cfg_write(1'b0, 3'd0, 1'b1, {6'b000000, 6'b011010}, 12'hFFF, 5'd20, 5'd1, 1'b0);

        // Priority and wildcard on table 2
        step("prio_idx0", 1'b0, 2'b10, 6'b100011, 6'b101010, 1'b0, 5'd23, 1'b0, 1'b0);
        step("wild_idx1", 1'b0, 2'b10, 6'b001000, 6'b000000, 1'b0, 5'd25, 1'b0, 1'b0);

        // Miss, trap and sticky illegal
        step("miss1",      1'b0, 2'b01, 6'd0, 6'b011000, 1'b0, 5'd31, 1'b1, 1'b1);
        step("miss_pulse", 1'b0, 2'b00, 6'd0, 6'd0,      1'b0, 5'd0,  1'b0, 1'b1);
        step("clr_vs_miss",1'b0, 2'b01, 6'd0, 6'b011000, 1'b1, 5'd31, 1'b1, 1'b1);
        step("clr_alone",  1'b0, 2'b00, 6'd0, 6'd0,      1'b1, 5'd0,  1'b0, 1'b0);

        // Write/lookup collision: old target seen, then new
        cfg_we = 1'b1; cfg_table = 1'b0; cfg_index = 3'd0; cfg_valid = 1'b1;
        cfg_key = {6'b000000, 6'b011010}; cfg_mask = 12'hFFF; cfg_target = 5'd21;
        step("coll_old", 1'b0, 2'b01, 6'd0, 6'b011010, 1'b0, 5'd20, 1'b0, 1'b0);
        step("coll_new", 1'b0, 2'b01, 6'd0, 6'b011010, 1'b0, 5'd21, 1'b0, 1'b0);

        // Reach upc = 7, then stall on a missing dispatch
        step("to_fetch", 1'b0, 2'b00, 6'd0, 6'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            step($sformatf("to7_%0d", i), 1'b0, 2'b11, 6'd0, 6'd0, 1'b0, 5'(i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step($sformatf("stall%0d", i), 1'b1, 2'b01, 6'd0, 6'b011000, 1'b0, 5'd7, 1'b0, 1'b0);
        end
        step("stall_rel", 1'b0, 2'b01, 6'd0, 6'b011000, 1'b0, 5'd31, 1'b1, 1'b1);

        // Reach upc = 23, then reset with a coincident write of a catch-all
        step("to23", 1'b0, 2'b10, 6'b100011, 6'b000000, 1'b0, 5'd23, 1'b0, 1'b1);
        rst = 1'b1;
        cfg_we = 1'b1; cfg_table = 1'b0; cfg_index = 3'd1; cfg_valid = 1'b1;
        cfg_key = 12'd0; cfg_mask = 12'd0; cfg_target = 5'd9;
        step("mid_rst", 1'b0, 2'b10, 6'b100011, 6'b000000, 1'b0, 5'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step("post_rst_t1", 1'b0, 2'b01, 6'd0, 6'b011010, 1'b0, 5'd31, 1'b1, 1'b1);
        step("post_rst_t2", 1'b0, 2'b10, 6'b100011, 6'd0, 1'b0, 5'd31, 1'b1, 1'b1);

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/micro_dispatch_seq.md
# micro_dispatch_seq

Parametrised microprogram sequencer with two run-time-programmable masked dispatch tables. It holds the micro-PC (uPC) and selects the next microstate each cycle: fetch, sequential, or a dispatch on the decoded {opcode, funct} key. Unlike the fixed combinational dispatch ROM it replaces, it has a defined trap state for unmatched keys, priority-ordered wildcard entries, and stall support. It sits between the instruction register and the control-store ROM, and drives the control-store address.

## Interface
- `STATE_W`, 5: uPC / target width.
- `OPC_W`, 6: opcode width.
- `FN_W`, 6: funct width; key width `KEY_W = OPC_W + FN_W`.
- `DT_DEPTH`, 8: entries per dispatch table; power of two, ≥2.
- `FETCH_STATE`, 0: uPC after reset and on a fetch.
- `TRAP_STATE`, 31: uPC on a dispatch miss.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hold uPC this cycle.
- `addr_ctl` in 2: from control store. 00 = fetch, 01 = dispatch table 1, 10 = dispatch table 2, 11 = sequential.
- `opcode` in OPC_W: instruction opcode.
- `funct` in FN_W: instruction funct.
- `cfg_we` in 1: table write strobe.
- `cfg_table` in 1: 0 = table 1, 1 = table 2.
- `cfg_index` in log2(DT_DEPTH): entry index to write.
- `cfg_valid` in 1: entry valid bit.
- `cfg_key` in KEY_W: entry key, {opcode, funct}.
- `cfg_mask` in KEY_W: 1 = compare this bit, 0 = don't-care.
- `cfg_target` in STATE_W: entry next state.
- `illegal_clr` in 1: clear the sticky illegal flag.
- `upc` out STATE_W: registered micro-PC.
- `miss` out 1: registered one-cycle pulse on a dispatch miss.
- `illegal` out 1: sticky flag, set by any miss.

## Operation
- Key is `{opcode, funct}`.
- Entry *i* of the selected table matches when `valid[i]` is set and `((key ^ key[i]) & mask[i]) == 0`.
- If several entries match, the lowest index wins.
- A hit loads `target[i]` into uPC.
- A miss (no match) loads `TRAP_STATE` into uPC, pulses `miss`, and sets `illegal`.
- Fetch (00) loads `FETCH_STATE`.
- Sequential (11) loads `upc + 1`, modulo 2^STATE_W; wraps with no flag.
- Priority: `rst` > `stall` > `addr_ctl`.
  - During a stall, uPC holds, `miss` = 0, `illegal` is not set, and lookups are not evaluated.
- `illegal` updates:
  - Clear: `illegal_clr` in a cycle with no miss.
  - Set wins: if a miss and `illegal_clr` occur in the same cycle, `illegal` = 1.
- Table writes:
  - Independent of `stall` and `addr_ctl`.
  - All four fields of the entry are written at once.
  - A write takes effect at the next edge. A lookup in the same cycle sees the old contents.
  - Writing `cfg_valid` = 0 disables the entry.
- Reset, in any state and mid-dispatch:
  - `upc` = `FETCH_STATE`, `miss` = 0, `illegal` = 0.
  - All entry valid bits = 0. Key, mask and target fields are not reset.
  - A `cfg_we` coincident with `rst` is ignored.
- Empty table (all entries invalid): every dispatch on it misses.
- An all-zero mask on a valid entry matches every key. Used as a catch-all at the highest index.

## Timing
- Lookup is combinational from `opcode`/`funct` and the table registers. The uPC update lands at the next rising edge: 1-cycle latency from `addr_ctl` to `upc`.
- `miss` is asserted in the cycle after the missing dispatch, coincident with `upc` = `TRAP_STATE`. It lasts exactly one cycle unless the next cycle also misses.
- `illegal` rises with `miss` and falls one cycle after `illegal_clr`.
- Config write to lookup visibility: the write at edge N is visible to a dispatch evaluated in cycle N+1.
- No combinational path from any input to any output.

## Test plan
- Reset and sequencing:
  - Stimulus: hold `rst` 2 cycles, then `addr_ctl` = 11 for 33 cycles with STATE_W = 5.
  - Required response: `upc` = 0 after reset, counts 1..31, wraps to 0, then 1. `miss` and `illegal` stay 0.
- Priority and wildcard:
  - Setup, table 2:
    - idx0: key {100011, 000000}, mask {111111, 000000}, target 23.
    - idx1: key 0, mask 0, target 25.
  - Stimulus: dispatch2 with opcode 100011, funct 101010.
  - Required response: `upc` = 23 next cycle.
  - Stimulus: dispatch2 with opcode 001000.
  - Required response: `upc` = 25.
- Miss and trap:
  - Setup: table 1 has only idx0, key {000000, 011010}, full mask, target 20.
  - Stimulus: dispatch1 with funct 011000.
  - Required response: next cycle `upc` = 31, `miss` = 1 for one cycle, `illegal` = 1 and it stays 1.
  - Stimulus: assert `illegal_clr` and a miss in the same cycle.
  - Required response: `illegal` stays 1.
  - Stimulus: `illegal_clr` alone.
  - Required response: `illegal` = 0.
- Write/lookup collision:
  - Stimulus: in the same cycle, write table 1 idx0 to target 21 and dispatch1 with the matching key.
  - Required response: `upc` = 20, the old target.
  - Stimulus: dispatch1 with the same key in the next cycle.
  - Required response: `upc` = 21.
- Stall:
  - Stimulus: at `upc` = 7, assert `stall` for 3 cycles with `addr_ctl` = 01 on a missing key.
  - Required response: `upc` stays 7, `miss` = 0, `illegal` = 0.
  - Stimulus: release `stall`.
  - Required response: `upc` = 31 and `miss` pulses.
- Reset mid-operation:
  - Setup: `upc` = 23 with table entries valid.
  - Stimulus: `rst` for 1 cycle together with a `cfg_we`.
  - Required response: `upc` = 0 and `illegal` = 0.
  - Stimulus: a subsequent dispatch on either table.
  - Required response: miss, `upc` = 31.
